pipe_skid_register: RTL and testbench
=====================================

Name: pipe_skid_register

Overview:
Parametrised elastic pipeline register. It is the successor to the fixed IF/ID register and is used between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces the plain enable-based stall with a valid/ready handshake and adds an optional 2-entry skid buffer, so ready does not ripple combinationally upstream. It also adds a synchronous flush that inserts a configurable bubble value, used for branch/jump squash.

Parameters:
DATA_W, 96, payload width in bits (default = instr + pc + pc_plus4).
BUBBLE_VAL, {DATA_W{1'b0}}, value driven on out_data whenever out_valid=0.
SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous squash of all held entries.
in_valid  input  1  upstream payload valid.
in_ready  output  1  block can accept this cycle.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  out_data holds a valid entry.
out_ready  input  1  downstream accepts this cycle.
out_data  output  DATA_W  payload to the next stage.
occupancy  output  2  number of valid entries held (0..2; 0..1 if SKID_EN=0).

Behaviour:
- Handshake terms:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - A transfer occurs on the rising edge where fire is high.
- Reset (rst_n=0, async, immediate):
  - out_valid=0, out_data=BUBBLE_VAL, occupancy=0.
  - Skid entry invalid, skid data=0.
  - in_ready=1.
  - Reset mid-transfer discards all held data with no partial state.
- Invariant: out_valid=0 implies out_data==BUBBLE_VAL at all times.
- SKID_EN=1 states (occupancy):
  - EMPTY(0): in_fire -> out<=in_data, go HALF.
  - HALF(1):
    - in_fire & out_fire -> out<=in_data, stay HALF.
    - in_fire & !out_fire -> skid<=in_data, go FULL.
    - !in_fire & out_fire -> out<=BUBBLE_VAL, go EMPTY.
    - Otherwise hold.
  - FULL(2):
    - in_ready=0.
    - out_fire -> out<=skid, skid invalid, go HALF.
    - Otherwise hold.
  - in_ready is a flop equal to !(next state == FULL). No combinational path from out_ready to in_ready.
- SKID_EN=0:
  - in_ready = !out_valid | out_ready (combinational).
  - in_fire -> out<=in_data.
  - out_fire & !in_fire -> out<=BUBBLE_VAL, valid cleared.
  - Skid logic absent; occupancy[1]=0.
- Ordering: strict FIFO order; no entry is duplicated or dropped except by flush.
- Flush (synchronous, priority below reset, above everything else):
  - Next edge: out_valid=0, out_data=BUBBLE_VAL, skid invalid, occupancy=0, in_ready=1.
  - Any in_fire in the flush cycle is discarded.
  - out_fire in the flush cycle still counts as consumed by downstream.
- Stall: out_ready=0 holds out_data/out_valid stable indefinitely. With SKID_EN=1, exactly one further beat is absorbed before in_ready drops.
- Latency: 1 cycle in_fire -> out_valid when the block is empty.
- Throughput: 1 beat/cycle with out_ready held high.
- No X propagation: in_data is not sampled when in_fire=0.

Test Plan:
1. Reset then stream: SKID_EN=1, DATA_W=96, in_valid=1 with payloads 1,2,3,4, out_ready=1 -> out_valid rises 1 cycle after the first fire; out_data = 1,2,3,4 on consecutive cycles; occupancy=1 throughout; in_ready=1.
2. Backpressure/skid:
   - Stream A,B,C with out_ready=0 from cycle 1.
   - Expect: out_data=A held; B captured in skid; occupancy=2; in_ready=0 the cycle after B fires; C not accepted.
   - Then out_ready=1 -> outputs B, then C, in order with no loss.
3. Flush:
   - With occupancy=2 (A out, B skid), assert flush for 1 cycle with in_valid=1, in_data=D.
   - Next cycle: out_valid=0, out_data=BUBBLE_VAL (test with BUBBLE_VAL=96'h13), occupancy=0, in_ready=1; D never appears.
4. Async reset mid-stall: at occupancy=2, pulse rst_n low between clock edges -> outputs go to reset values immediately, without waiting for an edge; after release, stream 5,6 flows normally.
5. Drain to bubble: send a single beat 0xAA, out_ready=1, then in_valid=0 -> one cycle of out_data=0xAA, then out_data=BUBBLE_VAL with out_valid=0.
6. SKID_EN=0:
   - out_valid=1 with out_ready=0 -> in_ready=0 in the same cycle.
   - out_ready=1 with in_valid=1 -> back-to-back transfer; occupancy never exceeds 1.

Source files
------------

// File: rtl/pipe_skid_register.sv
// rtl/pipe_skid_register.sv - elastic valid/ready pipeline register with optional 2-entry skid buffer and flush
module pipe_skid_register #(
  parameter int                DATA_W     = 96,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter int                SKID_EN    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = out_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Without a skid entry the upper occupancy bit can never be set.
  assign occupancy = (SKID_EN != 0) ? state_q : {1'b0, state_q[0]};

  // State, output entry and skid entry registers; out_q holds BUBBLE_VAL whenever empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= BUBBLE_VAL;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and next-data: flush wins, otherwise advance on the handshake terms.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      out_d   = BUBBLE_VAL;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            out_d   = in_data;
            state_d = ST_HALF;
          end
        end
        ST_HALF: begin
          if (in_fire && out_fire) begin
            out_d = in_data;
          end else if (in_fire) begin
            // Only reachable with a skid entry: single-entry in_ready implies out_fire here.
            if (SKID_EN != 0) begin
              skid_d  = in_data;
              state_d = ST_FULL;
            end
          end else if (out_fire) begin
            out_d   = BUBBLE_VAL;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            out_d   = skid_q;
            skid_d  = '0;
            state_d = ST_HALF;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          out_d   = BUBBLE_VAL;
          skid_d  = '0;
        end
      endcase
    end
  end

  generate
    if (SKID_EN != 0) begin : g_skid
      logic in_ready_q;

      // Registered ready: drops only when the next state is FULL, cutting the out_ready path.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != ST_FULL);
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_skid_register.sv
// tb/tb_pipe_skid_register.sv - self-checking bench for pipe_skid_register
module tb_pipe_skid_register;

  localparam int          W   = 96;
  localparam logic [W-1:0] BUB = 96'h13;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  logic         flush0 = 1'b0;
  logic         in_valid0 = 1'b0, out_ready0 = 1'b0;
  logic [W-1:0] in_data0 = '0;
  logic         in_ready0, out_valid0;
  logic [W-1:0] out_data0;
  logic [1:0]   occupancy0;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];

  always #5 clk = ~clk;

  pipe_skid_register #(.DATA_W(W), .BUBBLE_VAL(BUB), .SKID_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_skid_register #(.DATA_W(W), .BUBBLE_VAL(BUB), .SKID_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .occupancy(occupancy0)
  );

  // Scoreboard: push on in_fire, pop and compare on out_fire, sampled mid-cycle.
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    if (!rst_n) begin
      q1.delete();
      q0.delete();
    end else begin
      if (out_valid && out_ready) begin
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL sb_skid_extra actual=%h required=no output beat", out_data);
        end else begin
          exp_v = q1.pop_front();
          if (out_data !== exp_v) begin
            bad++;
            $display("FAIL sb_skid_order actual=%h required=%h", out_data, exp_v);
          end
        end
      end
      if (flush) q1.delete();
      else if (in_valid && in_ready) q1.push_back(in_data);

      if (out_valid0 && out_ready0) begin
        total++;
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL sb_noskid_extra actual=%h required=no output beat", out_data0);
        end else begin
          exp_v = q0.pop_front();
          if (out_data0 !== exp_v) begin
            bad++;
            $display("FAIL sb_noskid_order actual=%h required=%h", out_data0, exp_v);
          end
        end
      end
      if (in_valid0 && in_ready0) q0.push_back(in_data0);

      if (!out_valid) begin
        total++;
        if (out_data !== BUB) begin
          bad++;
          $display("FAIL bubble_inv actual=%h required=%h", out_data, BUB);
        end
      end
      total++;
      if (occupancy0 > 2'd1) begin
        bad++;
        $display("FAIL noskid_occ_max actual=%0d required=<=1", occupancy0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== BUB || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state actual=v%b d%h o%0d r%b required=v0 d%h o0 r1",
               out_valid, out_data, occupancy, in_ready, BUB);
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 96'd1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_pre actual=%b required=0", out_valid);
    end
    for (int i = 1; i <= 4; i++) begin
      in_data = W'(i);
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== W'(i) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stream_beat%0d actual=v%b d%h o%0d r%b required=v1 d%0d o1 r1",
                 i, out_valid, out_data, occupancy, in_ready, i);
      end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0 || out_data !== BUB) begin
      bad++;
      $display("FAIL stream_end actual=v%b d%h required=v0 d%h", out_valid, out_data, BUB);
    end
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 96'hA;
    tick();
    in_data = 96'hB;
    tick();
    total++;
    if (out_data !== 96'hA || occupancy !== 2'd2 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL skid_full actual=d%h o%0d r%b required=dA o2 r0", out_data, occupancy, in_ready);
    end
    in_data = 96'hC;
    tick();
    total++;
    if (out_data !== 96'hA || occupancy !== 2'd2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL skid_hold actual=v%b d%h o%0d r%b required=v1 dA o2 r0",
               out_valid, out_data, occupancy, in_ready);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_data !== 96'hB || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL skid_popB actual=d%h o%0d r%b required=dB o1 r1", out_data, occupancy, in_ready);
    end
    tick();
    total++;
    if (out_data !== 96'hC || occupancy !== 2'd1) begin
      bad++;
      $display("FAIL skid_popC actual=d%h o%0d required=dC o1", out_data, occupancy);
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      bad++;
      $display("FAIL skid_drain actual=v%b o%0d required=v0 o0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 96'hA1;
    tick();
    in_data = 96'hB1;
    tick();
    flush   = 1'b1;
    in_data = 96'hD;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_data !== BUB || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_state actual=v%b d%h o%0d r%b required=v0 d%h o0 r1",
               out_valid, out_data, occupancy, in_ready, BUB);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL flush_no_D actual=v%b d%h required=v0", out_valid, out_data);
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 96'hE1;
    tick();
    in_data = 96'hE2;
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== BUB || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset actual=v%b d%h o%0d r%b required=v0 d%h o0 r1",
               out_valid, out_data, occupancy, in_ready, BUB);
    end
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 96'd5;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 96'd5) begin
      bad++;
      $display("FAIL post_reset5 actual=v%b d%h required=v1 d5", out_valid, out_data);
    end
    in_data = 96'd6;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 96'd6) begin
      bad++;
      $display("FAIL post_reset6 actual=v%b d%h required=v1 d6", out_valid, out_data);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 96'hAA;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 96'hAA) begin
      bad++;
      $display("FAIL drain_beat actual=v%b d%h required=v1 dAA", out_valid, out_data);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || out_data !== BUB) begin
      bad++;
      $display("FAIL drain_bubble actual=v%b d%h required=v0 d%h", out_valid, out_data, BUB);
    end
  endtask

  task automatic test_noskid();
    out_ready0 = 1'b0;
    in_valid0  = 1'b1;
    in_data0   = 96'h11;
    tick();
    total++;
    if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || out_data0 !== 96'h11) begin
      bad++;
      $display("FAIL noskid_stall actual=v%b r%b d%h required=v1 r0 d11", out_valid0, in_ready0, out_data0);
    end
    tick();
    total++;
    if (out_data0 !== 96'h11 || occupancy0 !== 2'd1) begin
      bad++;
      $display("FAIL noskid_hold actual=d%h o%0d required=d11 o1", out_data0, occupancy0);
    end
    out_ready0 = 1'b1;
    #1;
    total++;
    if (in_ready0 !== 1'b1) begin
      bad++;
      $display("FAIL noskid_comb_ready actual=%b required=1", in_ready0);
    end
    for (int i = 0; i < 3; i++) begin
      in_data0 = W'(96'h12 + i);
      tick();
      total++;
      if (out_valid0 !== 1'b1 || out_data0 !== W'(96'h12 + i) || occupancy0 !== 2'd1 || in_ready0 !== 1'b1) begin
        bad++;
        $display("FAIL noskid_b2b%0d actual=v%b d%h o%0d r%b required=v1 d%h o1 r1",
                 i, out_valid0, out_data0, occupancy0, in_ready0, 96'h12 + i);
      end
    end
    in_valid0 = 1'b0;
    tick();
    total++;
    if (out_valid0 !== 1'b0 || out_data0 !== BUB || occupancy0 !== 2'd0) begin
      bad++;
      $display("FAIL noskid_drain actual=v%b d%h o%0d required=v0 d%h o0",
               out_valid0, out_data0, occupancy0, BUB);
    end
  endtask

  task automatic test_queues_empty();
    tick();
    total++;
    if (q1.size() != 0 || q0.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover actual=%0d/%0d required=0/0", q1.size(), q0.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_async_reset();
    test_drain();
    test_noskid();
    test_queues_empty();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
